pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 0; 1 means the register file returns same-cycle write data, so WB-stage producers raise no hazard.
REQ-002 SHALL have parameter CNT_W, default 16; width of the performance counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low; synchronous release.
REQ-005 ID_RS1_Addr_In, ID_RS2_Addr_In  in  5 each  source registers of the instruction held in IF_DE_REG.
REQ-006 ID_RS1_Used_In, ID_RS2_Used_In  in  1 each  source actually read by the decoded instruction type.
REQ-007 EX_RD_Addr_In, EX_Reg_Write_In  in  5/1  destination and write flag in the EX stage.
REQ-008 MA_RD_Addr_In, MA_Reg_Write_In  in  5/1  same for the MA stage.
REQ-009 WB_RD_Addr_In, WB_Reg_Write_In  in  5/1  same for the WB stage.
REQ-010 isBranchTaken_In  in  1  EX-stage redirect, valid one cycle.
REQ-011 Mem_Busy_In  in  1  data memory not ready; MA cannot complete this cycle.
REQ-012 PC_Write_En_Out, IF_DE_En_Out, ID_EX_En_Out, EX_MA_En_Out  out  1 each  stage-register load enables.
REQ-013 PC_Redirect_Out  out  1  IF loads the branch target instead of PC+4.
REQ-014 IF_DE_Flush_Out, ID_EX_Flush_Out  out  1 each  load a NOP bubble (0x00000013) instead of stage data.
REQ-015 Stall_Count_Out, Flush_Count_Out  out  CNT_W each  saturating event counters.

Function
REQ-016 States: RUN, DATA_STALL, MEM_WAIT, FLUSH; resolution priority, highest first: reset, Mem_Busy, branch, data hazard.
REQ-017 Hazard = used source != x0, equal to a producer rd with its write flag set, producers EX, MA, and WB only when WB_BYPASS=0.
REQ-018 Address 0 SHALL never raise a hazard, whatever the write flags.
REQ-019 RUN, no event: all enables 1, flushes 0, redirect 0.
REQ-020 Data hazard: PC_Write_En=0, IF_DE_En=0, ID_EX_Flush=1, EX_MA_En=1; next state DATA_STALL.
REQ-021 DATA_STALL holds these outputs while the hazard persists; return to RUN the cycle the hazard clears, outputs as REQ-019 in that cycle.
REQ-022 Branch (no Mem_Busy): PC_Redirect=1, IF_DE_Flush=1, ID_EX_Flush=1, all enables 1, in the same cycle as isBranchTaken_In; next state FLUSH.
REQ-023 Branch overrides a simultaneous data hazard.
REQ-024 FLUSH lasts exactly one cycle: hazard detection masked (ID holds a bubble), outputs as RUN; then RUN.
REQ-025 Mem_Busy: all four enables 0, flushes 0, redirect 0; state MEM_WAIT until Mem_Busy low.
REQ-026 A branch seen during Mem_Busy SHALL be latched in a pending flag and applied as REQ-022 on the first cycle Mem_Busy is low; the flag then clears.
REQ-027 Stall_Count increments each cycle PC_Write_En_Out=0; Flush_Count increments once per applied redirect; both saturate at all-ones, no wrap.

Reset
REQ-028 While rst_n=0: all enables 0, both flushes 1, redirect 0, pending flag 0, counters 0, state RUN.
REQ-029 Reset asserted mid-stall or mid-MEM_WAIT SHALL discard the pending branch and state immediately.
REQ-030 First cycle after release SHALL behave as RUN with the inputs then present.

Structure
REQ-031 State encoding, NOP constant 0x00000013 and x0 address SHALL live in the shared pipeline package.
REQ-032 Hazard comparison SHALL be one sub-module, hazard_detect (combinational), instantiated once; the FSM and counters live in the top.

Verification
REQ-033 ID rs1=5 used, EX rd=5 write=1 -> PC/IF_DE enables 0, ID_EX_Flush 1 for 3 cycles (EX, MA, WB), 4th cycle RUN; Stall_Count=3.
REQ-034 Same with WB_BYPASS=1 -> stall of 2 cycles only.
REQ-035 ID rs2=0 used, EX rd=0 write=1 -> no stall.
REQ-036 isBranchTaken and hazard same cycle -> redirect 1, both flushes 1, no stall; next cycle FLUSH, Flush_Count=1.
REQ-037 Mem_Busy high 4 cycles with branch in cycle 2 -> all enables 0 for 4 cycles, redirect in cycle 5 exactly once.
REQ-038 CNT_W=4, 20 stall cycles -> Stall_Count holds 15; rst_n low mid-MEM_WAIT -> outputs per REQ-028 within same cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: control FSM states, NOP bubble encoding,
// the hard-wired zero register and the source/destination match helper.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_DATA_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2,
      ST_FLUSH      = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [4:0]  X0_ADDR   = 5'd0;

   // x0 is hard-wired to zero, so it can never carry a dependency.
   function automatic logic src_hit(input logic [4:0] src, input logic used,
                                    input logic [4:0] rd, input logic we);
      return used && we && (src != X0_ADDR) && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID-stage sources and the
// EX/MA(/WB) destinations.
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned WB_BYPASS = 32'd0
) (
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   input  logic       rs1_used,
   input  logic       rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_we,
   input  logic [4:0] ma_rd,
   input  logic       ma_we,
   input  logic [4:0] wb_rd,
   input  logic       wb_we,
   output logic       hazard
);

   logic ex_hit_s;
   logic ma_hit_s;
   logic wb_hit_s;

   // With a write-through register file the WB producer is already visible.
   always_comb begin
      ex_hit_s = src_hit(rs1_addr, rs1_used, ex_rd, ex_we) |
                 src_hit(rs2_addr, rs2_used, ex_rd, ex_we);
      ma_hit_s = src_hit(rs1_addr, rs1_used, ma_rd, ma_we) |
                 src_hit(rs2_addr, rs2_used, ma_rd, ma_we);
      wb_hit_s = (src_hit(rs1_addr, rs1_used, wb_rd, wb_we) |
                  src_hit(rs2_addr, rs2_used, wb_rd, wb_we)) &&
                 (WB_BYPASS == 32'd0);
      hazard   = ex_hit_s | ma_hit_s | wb_hit_s;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory waits, branch redirects and
// RAW data stalls into stage enables/flushes, with saturating event counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned WB_BYPASS = 32'd0,
   parameter int unsigned CNT_W     = 32'd16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ID_RS1_Addr_In,
   input  logic [4:0]       ID_RS2_Addr_In,
   input  logic             ID_RS1_Used_In,
   input  logic             ID_RS2_Used_In,
   input  logic [4:0]       EX_RD_Addr_In,
   input  logic             EX_Reg_Write_In,
   input  logic [4:0]       MA_RD_Addr_In,
   input  logic             MA_Reg_Write_In,
   input  logic [4:0]       WB_RD_Addr_In,
   input  logic             WB_Reg_Write_In,
   input  logic             isBranchTaken_In,
   input  logic             Mem_Busy_In,
   output logic             PC_Write_En_Out,
   output logic             IF_DE_En_Out,
   output logic             ID_EX_En_Out,
   output logic             EX_MA_En_Out,
   output logic             PC_Redirect_Out,
   output logic             IF_DE_Flush_Out,
   output logic             ID_EX_Flush_Out,
   output logic [CNT_W-1:0] Stall_Count_Out,
   output logic [CNT_W-1:0] Flush_Count_Out
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic hazard_raw_s;
   logic hazard_s;
   logic pc_we_s, if_de_en_s, id_ex_en_s, ex_ma_en_s;
   logic redirect_s, if_de_flush_s, id_ex_flush_s;

   hazard_detect #(.WB_BYPASS(WB_BYPASS)) u_hazard_detect (
      .rs1_addr (ID_RS1_Addr_In),
      .rs2_addr (ID_RS2_Addr_In),
      .rs1_used (ID_RS1_Used_In),
      .rs2_used (ID_RS2_Used_In),
      .ex_rd    (EX_RD_Addr_In),
      .ex_we    (EX_Reg_Write_In),
      .ma_rd    (MA_RD_Addr_In),
      .ma_we    (MA_Reg_Write_In),
      .wb_rd    (WB_RD_Addr_In),
      .wb_we    (WB_Reg_Write_In),
      .hazard   (hazard_raw_s)
   );

   // Event resolution: reset > memory wait > branch (live or pending) > data hazard.
   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      pc_we_s       = 1'b1;
      if_de_en_s    = 1'b1;
      id_ex_en_s    = 1'b1;
      ex_ma_en_s    = 1'b1;
      redirect_s    = 1'b0;
      if_de_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      // ID holds a bubble in the cycle after a flush.
      hazard_s      = hazard_raw_s && (state_q != ST_FLUSH);
      if (!rst_n) begin
         state_d       = ST_RUN;
         pend_d        = 1'b0;
         pc_we_s       = 1'b0;
         if_de_en_s    = 1'b0;
         id_ex_en_s    = 1'b0;
         ex_ma_en_s    = 1'b0;
         if_de_flush_s = 1'b1;
         id_ex_flush_s = 1'b1;
      end else if (Mem_Busy_In) begin
         state_d    = ST_MEM_WAIT;
         pend_d     = pend_q | isBranchTaken_In;
         pc_we_s    = 1'b0;
         if_de_en_s = 1'b0;
         id_ex_en_s = 1'b0;
         ex_ma_en_s = 1'b0;
      end else if (isBranchTaken_In || pend_q) begin
         state_d       = ST_FLUSH;
         pend_d        = 1'b0;
         redirect_s    = 1'b1;
         if_de_flush_s = 1'b1;
         id_ex_flush_s = 1'b1;
      end else if (hazard_s) begin
         state_d       = ST_DATA_STALL;
         pc_we_s       = 1'b0;
         if_de_en_s    = 1'b0;
         id_ex_flush_s = 1'b1;
      end else begin
         state_d = ST_RUN;
      end
   end

   // Saturating stall and redirect counters.
   always_comb begin
      if (!pc_we_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (redirect_s && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Controller state and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         pend_q      <= 1'b0;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign PC_Write_En_Out = pc_we_s;
   assign IF_DE_En_Out    = if_de_en_s;
   assign ID_EX_En_Out    = id_ex_en_s;
   assign EX_MA_En_Out    = ex_ma_en_s;
   assign PC_Redirect_Out = redirect_s;
   assign IF_DE_Flush_Out = if_de_flush_s;
   assign ID_EX_Flush_Out = id_ex_flush_s;
   assign Stall_Count_Out = stall_cnt_q;
   assign Flush_Count_Out = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default, WB-bypass and 4-bit
// counter instances share one stimulus stream.
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] V_RUN   = 7'b1111_000;
   localparam logic [6:0] V_RST   = 7'b0000_011;
   localparam logic [6:0] V_STALL = 7'b0011_001;
   localparam logic [6:0] V_BR    = 7'b1111_111;
   localparam logic [6:0] V_MEM   = 7'b0000_000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1, rs2, ex_rd, ma_rd, wb_rd;
   logic       rs1_u, rs2_u, ex_we, ma_we, wb_we, br, mbusy;

   logic        a_pc, a_ifde, a_idex, a_exma, a_red, a_iff, a_idf;
   logic [15:0] a_stall, a_flush;
   logic        b_pc, b_ifde, b_idex, b_exma, b_red, b_iff, b_idf;
   logic [15:0] b_stall, b_flush;
   logic        c_pc, c_ifde, c_idex, c_exma, c_red, c_iff, c_idf;
   logic [3:0]  c_stall, c_flush;

   logic [6:0] a_vec, b_vec, c_vec;
   assign a_vec = {a_pc, a_ifde, a_idex, a_exma, a_red, a_iff, a_idf};
   assign b_vec = {b_pc, b_ifde, b_idex, b_exma, b_red, b_iff, b_idf};
   assign c_vec = {c_pc, c_ifde, c_idex, c_exma, c_red, c_iff, c_idf};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ID_RS1_Addr_In(rs1), .ID_RS2_Addr_In(rs2),
      .ID_RS1_Used_In(rs1_u), .ID_RS2_Used_In(rs2_u),
      .EX_RD_Addr_In(ex_rd), .EX_Reg_Write_In(ex_we),
      .MA_RD_Addr_In(ma_rd), .MA_Reg_Write_In(ma_we),
      .WB_RD_Addr_In(wb_rd), .WB_Reg_Write_In(wb_we),
      .isBranchTaken_In(br), .Mem_Busy_In(mbusy),
      .PC_Write_En_Out(a_pc), .IF_DE_En_Out(a_ifde), .ID_EX_En_Out(a_idex),
      .EX_MA_En_Out(a_exma), .PC_Redirect_Out(a_red),
      .IF_DE_Flush_Out(a_iff), .ID_EX_Flush_Out(a_idf),
      .Stall_Count_Out(a_stall), .Flush_Count_Out(a_flush)
   );

   pipeline_hazard_ctrl #(.WB_BYPASS(32'd1)) dut_byp (
      .clk(clk), .rst_n(rst_n),
      .ID_RS1_Addr_In(rs1), .ID_RS2_Addr_In(rs2),
      .ID_RS1_Used_In(rs1_u), .ID_RS2_Used_In(rs2_u),
      .EX_RD_Addr_In(ex_rd), .EX_Reg_Write_In(ex_we),
      .MA_RD_Addr_In(ma_rd), .MA_Reg_Write_In(ma_we),
      .WB_RD_Addr_In(wb_rd), .WB_Reg_Write_In(wb_we),
      .isBranchTaken_In(br), .Mem_Busy_In(mbusy),
      .PC_Write_En_Out(b_pc), .IF_DE_En_Out(b_ifde), .ID_EX_En_Out(b_idex),
      .EX_MA_En_Out(b_exma), .PC_Redirect_Out(b_red),
      .IF_DE_Flush_Out(b_iff), .ID_EX_Flush_Out(b_idf),
      .Stall_Count_Out(b_stall), .Flush_Count_Out(b_flush)
   );

   pipeline_hazard_ctrl #(.CNT_W(32'd4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .ID_RS1_Addr_In(rs1), .ID_RS2_Addr_In(rs2),
      .ID_RS1_Used_In(rs1_u), .ID_RS2_Used_In(rs2_u),
      .EX_RD_Addr_In(ex_rd), .EX_Reg_Write_In(ex_we),
      .MA_RD_Addr_In(ma_rd), .MA_Reg_Write_In(ma_we),
      .WB_RD_Addr_In(wb_rd), .WB_Reg_Write_In(wb_we),
      .isBranchTaken_In(br), .Mem_Busy_In(mbusy),
      .PC_Write_En_Out(c_pc), .IF_DE_En_Out(c_ifde), .ID_EX_En_Out(c_idex),
      .EX_MA_En_Out(c_exma), .PC_Redirect_Out(c_red),
      .IF_DE_Flush_Out(c_iff), .ID_EX_Flush_Out(c_idf),
      .Stall_Count_Out(c_stall), .Flush_Count_Out(c_flush)
   );

   task automatic set_idle();
      rs1 = 5'd0; rs2 = 5'd0; rs1_u = 1'b0; rs2_u = 1'b0;
      ex_rd = 5'd0; ma_rd = 5'd0; wb_rd = 5'd0;
      ex_we = 1'b0; ma_we = 1'b0; wb_we = 1'b0;
      br = 1'b0; mbusy = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      set_idle();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_vec !== V_RST) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", a_vec, V_RST); end
      checks++;
      if (a_stall !== 16'd0 || a_flush !== 16'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", a_stall, a_flush); end
      cyc();
      // Release with a live EX dependency: first cycle must already resolve it.
      rst_n = 1'b1;
      rs1 = 5'd7; rs1_u = 1'b1; ex_rd = 5'd7; ex_we = 1'b1;
      #1;
      checks++;
      if (a_vec !== V_STALL) begin errors++; $display("FAIL release_first_cycle got=%b exp=%b", a_vec, V_STALL); end
      set_idle();
      #1;
      checks++;
      if (a_vec !== V_RUN) begin errors++; $display("FAIL release_run got=%b exp=%b", a_vec, V_RUN); end
   endtask

   task automatic test_raw_stall();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      exp_a = '{V_STALL, V_STALL, V_STALL, V_RUN};
      exp_b = '{V_STALL, V_STALL, V_RUN, V_RUN};
      apply_reset();
      rs1 = 5'd5; rs1_u = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ex_rd = (i == 0) ? 5'd5 : 5'd0; ex_we = (i == 0);
         ma_rd = (i == 1) ? 5'd5 : 5'd0; ma_we = (i == 1);
         wb_rd = (i == 2) ? 5'd5 : 5'd0; wb_we = (i == 2);
         #1;
         checks++;
         if (a_vec !== exp_a[i]) begin errors++; $display("FAIL raw_stall_c%0d got=%b exp=%b", i, a_vec, exp_a[i]); end
         checks++;
         if (b_vec !== exp_b[i]) begin errors++; $display("FAIL raw_bypass_c%0d got=%b exp=%b", i, b_vec, exp_b[i]); end
         cyc();
      end
      checks++;
      if (a_stall !== 16'd3) begin errors++; $display("FAIL raw_stall_count got=%0d exp=3", a_stall); end
      checks++;
      if (b_stall !== 16'd2) begin errors++; $display("FAIL raw_bypass_count got=%0d exp=2", b_stall); end
      set_idle();
   endtask

   task automatic test_x0();
      apply_reset();
      rs2 = 5'd0; rs2_u = 1'b1; rs1 = 5'd0; rs1_u = 1'b1;
      ex_rd = 5'd0; ex_we = 1'b1; ma_rd = 5'd0; ma_we = 1'b1; wb_rd = 5'd0; wb_we = 1'b1;
      #1;
      checks++;
      if (a_vec !== V_RUN) begin errors++; $display("FAIL x0_no_stall got=%b exp=%b", a_vec, V_RUN); end
      cyc();
      checks++;
      if (a_stall !== 16'd0) begin errors++; $display("FAIL x0_stall_count got=%0d exp=0", a_stall); end
      // Unused source matching a producer is not a dependency.
      rs2 = 5'd9; rs2_u = 1'b0; rs1_u = 1'b0; ex_rd = 5'd9;
      #1;
      checks++;
      if (a_vec !== V_RUN) begin errors++; $display("FAIL unused_src got=%b exp=%b", a_vec, V_RUN); end
      set_idle();
   endtask

   task automatic test_branch_hazard();
      apply_reset();
      rs2 = 5'd12; rs2_u = 1'b1; ex_rd = 5'd12; ex_we = 1'b1; br = 1'b1;
      #1;
      checks++;
      if (a_vec !== V_BR) begin errors++; $display("FAIL branch_over_hazard got=%b exp=%b", a_vec, V_BR); end
      cyc();
      br = 1'b0;
      #1;
      checks++;
      if (a_vec !== V_RUN) begin errors++; $display("FAIL flush_masks_hazard got=%b exp=%b", a_vec, V_RUN); end
      checks++;
      if (a_flush !== 16'd1 || a_stall !== 16'd0) begin errors++; $display("FAIL branch_counts got=%0d/%0d exp=1/0", a_flush, a_stall); end
      cyc();
      #1;
      checks++;
      if (a_vec !== V_STALL) begin errors++; $display("FAIL hazard_after_flush got=%b exp=%b", a_vec, V_STALL); end
      set_idle();
   endtask

   task automatic test_mem_branch();
      int redirects = 0;
      apply_reset();
      for (int i = 1; i <= 6; i++) begin
         mbusy = (i <= 4);
         br = (i == 2);
         #1;
         if (a_red === 1'b1) redirects++;
         if (i <= 4) begin
            checks++;
            if (a_vec !== V_MEM) begin errors++; $display("FAIL mem_wait_c%0d got=%b exp=%b", i, a_vec, V_MEM); end
         end else if (i == 5) begin
            checks++;
            if (a_vec !== V_BR) begin errors++; $display("FAIL pending_branch got=%b exp=%b", a_vec, V_BR); end
         end else begin
            checks++;
            if (a_vec !== V_RUN) begin errors++; $display("FAIL after_pending got=%b exp=%b", a_vec, V_RUN); end
         end
         cyc();
      end
      checks++;
      if (redirects != 1) begin errors++; $display("FAIL redirect_once got=%0d exp=1", redirects); end
      checks++;
      if (a_stall !== 16'd4 || a_flush !== 16'd1) begin errors++; $display("FAIL mem_counts got=%0d/%0d exp=4/1", a_stall, a_flush); end
      set_idle();
   endtask

   task automatic test_saturation_and_reset();
      apply_reset();
      mbusy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         br = (i == 19);
         cyc();
      end
      br = 1'b0;
      checks++;
      if (c_stall !== 4'd15) begin errors++; $display("FAIL stall_saturate got=%0d exp=15", c_stall); end
      checks++;
      if (a_stall !== 16'd20) begin errors++; $display("FAIL stall_wide got=%0d exp=20", a_stall); end
      // Asynchronous reset mid-wait, with a branch pending.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_vec !== V_RST || c_vec !== V_RST) begin errors++; $display("FAIL async_reset got=%b/%b exp=%b", a_vec, c_vec, V_RST); end
      checks++;
      if (a_stall !== 16'd0 || c_stall !== 4'd0) begin errors++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", a_stall, c_stall); end
      cyc();
      rst_n = 1'b1;
      mbusy = 1'b0;
      #1;
      checks++;
      if (a_vec !== V_RUN) begin errors++; $display("FAIL pending_discarded got=%b exp=%b", a_vec, V_RUN); end
      set_idle();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_raw_stall();
      test_x0();
      test_branch_hazard();
      test_mem_branch();
      test_saturation_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
